// File: rtl/board_shuffle_ctrl_if.sv
// board_shuffle_ctrl_if: control, gameplay write and board RAM signals of board_shuffle_ctrl
interface board_shuffle_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 6
);
  logic              Start;
  logic [7:0]        seed;
  logic              GpWe;
  logic [ADDR_W-1:0] GpLoc;
  logic [DATA_W-1:0] GpData;
  logic [DATA_W-1:0] MemRdata;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic              Busy;
  logic              Done;
  logic [7:0]        state;
  modport master (
    output Start, seed, GpWe, GpLoc, GpData, MemRdata,
    input  MemWe, MemAddr, MemWdata, Busy, Done, state
  );
  modport slave (
    input  Start, seed, GpWe, GpLoc, GpData, MemRdata,
    output MemWe, MemAddr, MemWdata, Busy, Done, state
  );
endinterface

// File: rtl/board_shuffle_ctrl.sv
// board_shuffle_ctrl: fills the card board with pairs, then Fisher-Yates shuffles it.
// Define BOARD_SHUFFLE_EN to build the LFSR shuffle; otherwise FILL goes straight to DONE.
module board_shuffle_ctrl #(
  parameter int NUM_CARDS = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 6,
  parameter int VAL_BASE  = 1
) (
  input logic                 Clk,
  input logic                 Reset,
  board_shuffle_ctrl_if.slave bus
);
  localparam logic [7:0] S_IDLE = 8'h01;
  localparam logic [7:0] S_FILL = 8'h02;
  localparam logic [7:0] S_PICK = 8'h04;
  localparam logic [7:0] S_RD_I = 8'h08;
  localparam logic [7:0] S_RD_J = 8'h10;
  localparam logic [7:0] S_WR_I = 8'h20;
  localparam logic [7:0] S_WR_J = 8'h40;
  localparam logic [7:0] S_DONE = 8'h80;
  logic [7:0]        st, st_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill_val;
  logic              idle, fill, fill_last;
  assign idle      = st == S_IDLE;
  assign fill      = st == S_FILL;
  assign fill_last = cnt == ADDR_W'(NUM_CARDS - 1);
  assign fill_val  = DATA_W'(VAL_BASE) + DATA_W'(cnt[ADDR_W-1:1]);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= fill ? cnt + 1'b1 : idle ? '0 : cnt;
    end
`ifdef BOARD_SHUFFLE_EN
  logic [7:0]        lfsr, lfsr_nx;
  logic [ADDR_W-1:0] i, j, pj, i_dec;
  logic [DATA_W-1:0] vi;
  logic              dec;
  assign lfsr_nx = lfsr[0] ? (lfsr >> 1) ^ 8'hB8 : lfsr >> 1;
  assign pj      = lfsr[ADDR_W-1:0];
  assign i_dec   = i - 1'b1;
  assign dec     = (st == S_PICK && pj == i) || st == S_WR_J;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      lfsr <= 8'h01;
      i    <= ADDR_W'(NUM_CARDS - 1);
      j    <= '0;
      vi   <= '0;
    end else begin
      if (idle && bus.Start) lfsr <= bus.seed == 8'h00 ? 8'h01 : bus.seed;
      else if (st == S_PICK) lfsr <= lfsr_nx;
      if (idle && bus.Start) i <= ADDR_W'(NUM_CARDS - 1);
      else if (dec) i <= i_dec;
      if (st == S_PICK) j <= pj;
      if (st == S_RD_J) vi <= bus.MemRdata;
    end
  always_comb begin
    st_nx = S_IDLE;
    case (st)
      S_IDLE: st_nx = bus.Start ? S_FILL : S_IDLE;
      S_FILL: st_nx = fill_last ? S_PICK : S_FILL;
      S_PICK: st_nx = pj > i ? S_PICK : pj == i ? (i_dec == '0 ? S_DONE : S_PICK) : S_RD_I;
      S_RD_I: st_nx = S_RD_J;
      S_RD_J: st_nx = S_WR_I;
      S_WR_I: st_nx = S_WR_J;
      S_WR_J: st_nx = i_dec == '0 ? S_DONE : S_PICK;
      default: st_nx = S_IDLE;
    endcase
  end
  // RD_J returns v[i] (latched as vi); WR_I sees v[j] on MemRdata
  assign bus.MemWe    = idle ? bus.GpWe : fill || st == S_WR_I || st == S_WR_J;
  assign bus.MemAddr  = idle ? bus.GpLoc : fill ? cnt : (st == S_RD_I || st == S_WR_I) ? i : j;
  assign bus.MemWdata = idle ? bus.GpData : fill ? fill_val : st == S_WR_I ? bus.MemRdata : vi;
`else
  logic unused_ok;
  assign unused_ok = ^{bus.seed, bus.MemRdata};
  always_comb begin
    st_nx = S_IDLE;
    case (st)
      S_IDLE: st_nx = bus.Start ? S_FILL : S_IDLE;
      S_FILL: st_nx = fill_last ? S_DONE : S_FILL;
      default: st_nx = S_IDLE;
    endcase
  end
  assign bus.MemWe    = idle ? bus.GpWe : fill;
  assign bus.MemAddr  = idle ? bus.GpLoc : cnt;
  assign bus.MemWdata = idle ? bus.GpData : fill_val;
`endif
  assign bus.Busy  = !idle;
  assign bus.Done  = st == S_DONE;
  assign bus.state = st;
endmodule

// File: tb/tb_board_shuffle_ctrl.sv
// tb_board_shuffle_ctrl: directed bench for board_shuffle_ctrl with a 1-cycle-latency model RAM.
module tb_board_shuffle_ctrl;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] ram [16];
  logic [5:0] rd;
  board_shuffle_ctrl_if #(.ADDR_W(4), .DATA_W(6)) bus ();
  board_shuffle_ctrl #(.NUM_CARDS(16), .ADDR_W(4), .DATA_W(6), .VAL_BASE(1)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  always #5 Clk = ~Clk;
  assign bus.MemRdata = rd;
  always @(posedge Clk) begin
    if (bus.MemWe) ram[bus.MemAddr] <= bus.MemWdata;
    rd <= ram[bus.MemAddr];
  end
  task automatic wait_idle(input string name);
    for (int n = 0; n < 4000 && bus.state !== 8'h01; n++) @(negedge Clk);
    vectors++;
    if (bus.state !== 8'h01) begin
      miscompares++;
      $display("FAIL %s timeout: state=%h want 01", name, bus.state);
    end
  endtask
  task automatic test_reset;
    bus.Start = 0; bus.seed = 0; bus.GpWe = 0; bus.GpLoc = 0; bus.GpData = 0;
    Reset = 0;
    repeat (3) @(negedge Clk);
    #1;
    vectors++; if (bus.state !== 8'h01) begin miscompares++; $display("FAIL reset_state got=%h want=01", bus.state); end
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", bus.Done); end
    vectors++; if (bus.MemWe !== 1'b0) begin miscompares++; $display("FAIL reset_memwe got=%b want=0", bus.MemWe); end
    Reset = 1;
  endtask
  task automatic test_passthrough;
    @(negedge Clk);
    bus.GpWe = 1; bus.GpLoc = 4'd5; bus.GpData = 6'h3F;
    #1;
    vectors++; if ({bus.MemWe, bus.MemAddr, bus.MemWdata} !== {1'b1, 4'd5, 6'h3F}) begin
      miscompares++; $display("FAIL pass_write got we=%b addr=%h data=%h want 1/5/3f", bus.MemWe, bus.MemAddr, bus.MemWdata);
    end
    @(negedge Clk);
    bus.GpWe = 0; bus.GpLoc = 4'hA; bus.GpData = 6'h15;
    #1;
    vectors++; if ({bus.MemWe, bus.MemAddr, bus.MemWdata} !== {1'b0, 4'hA, 6'h15}) begin
      miscompares++; $display("FAIL pass_idle got we=%b addr=%h data=%h want 0/a/15", bus.MemWe, bus.MemAddr, bus.MemWdata);
    end
    @(negedge Clk);
    vectors++; if (bus.state !== 8'h01 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL pass_stay_idle got state=%h busy=%b want 01/0", bus.state, bus.Busy);
    end
  endtask
  task automatic test_fill;
    logic [18:0] got, want;
    @(negedge Clk);
    bus.Start = 1; bus.GpWe = 1; bus.GpLoc = 4'd9; bus.GpData = 6'h2A;
    #1;
    vectors++; if ({bus.MemWe, bus.MemAddr, bus.MemWdata} !== {1'b1, 4'd9, 6'h2A}) begin
      miscompares++; $display("FAIL start_gp_write got we=%b addr=%h data=%h want 1/9/2a", bus.MemWe, bus.MemAddr, bus.MemWdata);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      if (k == 0) begin bus.Start = 0; bus.GpLoc = 4'd5; bus.GpData = 6'h3F; end
      #1;
      got  = {bus.state, bus.Busy, bus.Done, bus.MemWe, bus.MemAddr, bus.MemWdata};
      want = {8'h02, 1'b1, 1'b0, 1'b1, 4'(k), 6'(1 + k / 2)};
      vectors++; if (got !== want) begin
        miscompares++; $display("FAIL fill_cycle%0d got=%h want=%h", k, got, want);
      end
    end
    @(negedge Clk);
    #1;
`ifdef BOARD_SHUFFLE_EN
    vectors++; if (bus.state !== 8'h04 || bus.Done !== 1'b0) begin
      miscompares++; $display("FAIL fill_to_pick got state=%h done=%b want 04/0", bus.state, bus.Done);
    end
    bus.GpWe = 0;
    wait_idle("fill_finish");
`else
    vectors++; if ({bus.state, bus.Busy, bus.Done} !== {8'h80, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL done_cycle17 got state=%h busy=%b done=%b want 80/1/1", bus.state, bus.Busy, bus.Done);
    end
    @(negedge Clk);
    #1;
    vectors++; if ({bus.state, bus.Busy, bus.Done} !== {8'h01, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL after_done got state=%h busy=%b done=%b want 01/0/0", bus.state, bus.Busy, bus.Done);
    end
    bus.GpWe = 0;
`endif
  endtask
  task automatic test_reset_mid;
    int dones = 0;
    @(negedge Clk); bus.Start = 1;
    @(negedge Clk); bus.Start = 0;
`ifdef BOARD_SHUFFLE_EN
    for (int n = 0; n < 100 && bus.state !== 8'h04; n++) @(negedge Clk);
    vectors++; if (bus.state !== 8'h04) begin miscompares++; $display("FAIL reach_pick got=%h want=04", bus.state); end
`else
    repeat (5) @(negedge Clk);
`endif
    #2 Reset = 0;
    #1;
    vectors++; if ({bus.state, bus.Busy, bus.Done} !== {8'h01, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL mid_reset got state=%h busy=%b done=%b want 01/0/0", bus.state, bus.Busy, bus.Done);
    end
    repeat (2) @(negedge Clk);
    Reset = 1;
    repeat (20) begin @(negedge Clk); if (bus.Done === 1'b1) dones++; end
    vectors++; if (dones != 0 || bus.state !== 8'h01) begin
      miscompares++; $display("FAIL mid_reset_no_done got dones=%0d state=%h want 0/01", dones, bus.state);
    end
    bus.Start = 1;
    @(negedge Clk); bus.Start = 0;
    #1;
    vectors++; if ({bus.state, bus.MemWe, bus.MemAddr, bus.MemWdata} !== {8'h02, 1'b1, 4'd0, 6'd1}) begin
      miscompares++; $display("FAIL restart_fill got state=%h we=%b addr=%h data=%h want 02/1/0/1", bus.state, bus.MemWe, bus.MemAddr, bus.MemWdata);
    end
    wait_idle("restart_finish");
  endtask
`ifdef BOARD_SHUFFLE_EN
  task automatic run_shuffle(input logic [7:0] s, output logic [95:0] snap);
    int dones = 0;
    int hist [9];
    @(negedge Clk); bus.Start = 1; bus.seed = s;
    @(negedge Clk); bus.Start = 0;
    for (int n = 0; n < 4000 && bus.state !== 8'h01; n++) begin
      if (bus.Done === 1'b1) dones++;
      @(negedge Clk);
    end
    vectors++; if (dones != 1 || bus.state !== 8'h01) begin
      miscompares++; $display("FAIL shuffle_%h_done got dones=%0d state=%h want 1/01", s, dones, bus.state);
    end
    for (int v = 0; v < 9; v++) hist[v] = 0;
    for (int k = 0; k < 16; k++) begin
      snap[k*6 +: 6] = ram[k];
      if (ram[k] >= 6'd1 && ram[k] <= 6'd8) hist[ram[k]]++;
    end
    for (int v = 1; v < 9; v++) begin
      vectors++; if (hist[v] != 2) begin
        miscompares++; $display("FAIL shuffle_%h_value%0d got count=%0d want 2", s, v, hist[v]);
      end
    end
  endtask
  task automatic test_shuffle;
    logic [95:0] a, b, c, d, e;
    run_shuffle(8'hA5, a);
    run_shuffle(8'hA5, b);
    vectors++; if (b !== a) begin miscompares++; $display("FAIL rerun_a5 got=%h want=%h", b, a); end
    run_shuffle(8'h3C, c);
    vectors++; if (c === a) begin miscompares++; $display("FAIL seed_3c_differs got=%h want not %h", c, a); end
    run_shuffle(8'h00, d);
    run_shuffle(8'h01, e);
    vectors++; if (d !== e) begin miscompares++; $display("FAIL seed0_eq_seed1 got=%h want=%h", d, e); end
  endtask
`endif
  initial begin
    test_reset;
    test_passthrough;
    test_fill;
`ifdef BOARD_SHUFFLE_EN
    test_shuffle;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
